// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
// Holds the opcode map, the control FSM state encoding, the ALUOp, PCSrc and
// RegDst codes, and a small opcode classifier used by the controller.
package cpu_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011011;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Control FSM states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Next-PC sources
  localparam logic [1:0] PC_SEQ = 2'b00;  // PC+4
  localparam logic [1:0] PC_BR  = 2'b01;  // PC+4+(imm<<2)
  localparam logic [1:0] PC_RS  = 2'b10;  // rs
  localparam logic [1:0] PC_JMP = 2'b11;  // jump target

  // Destination register selects
  localparam logic [1:0] RD_RA = 2'b00;   // $31
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [2:0] {
    OC_ALU_R,
    OC_ALU_I,
    OC_MEM,
    OC_BRANCH,
    OC_JUMP,
    OC_HALT,
    OC_UNDEF
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND:    return OC_ALU_R;
      OP_ADDIU, OP_ORI, OP_SLTI: return OC_ALU_I;
      OP_SW, OP_LW:              return OC_MEM;
      OP_BEQ, OP_BNE:            return OC_BRANCH;
      OP_J, OP_JR, OP_JAL:       return OC_JUMP;
      OP_HALT:                   return OC_HALT;
      default:                   return OC_UNDEF;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;   // add, addiu
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decoder for the multi-cycle CPU.
// Inputs : state (current FSM state), opcode (IR[31:26]), zero/sign (ALU flags).
// Outputs: every datapath enable and mux select. Outputs not driven for a
//          given state/opcode stay 0. Reset gating is applied by the parent.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        ExtSel,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc
);

  op_class_t op_cls;
  logic      unused_sign;

  assign op_cls      = op_class(opcode);
  // No instruction in this ISA branches on the sign flag yet.
  assign unused_sign = sign;

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PC_SEQ;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RD_RA;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;

    case (state)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end

      // Jumps and unknown opcodes finish in ID; halt deliberately drives nothing.
      S_ID: begin
        case (opcode)
          OP_J: begin
            PCWre = 1'b1;
            PCSrc = PC_JMP;
          end
          OP_JR: begin
            PCWre = 1'b1;
            PCSrc = PC_RS;
          end
          OP_JAL: begin
            PCWre     = 1'b1;
            PCSrc     = PC_JMP;
            RegWre    = 1'b1;
            RegDst    = RD_RA;
            WrRegDSrc = 1'b0;  // link value is PC+4
          end
          default: begin
            if (op_cls == OC_UNDEF) begin
              PCWre = 1'b1;
              PCSrc = PC_SEQ;
            end
          end
        endcase
      end

      // ALU selects stay put through write-back so the result is still valid.
      S_EXE_AL, S_WB_AL: begin
        ALUOp   = alu_op_for(opcode);
        ALUSrcB = (op_cls == OC_ALU_I);
        ExtSel  = (opcode == OP_ADDIU) || (opcode == OP_SLTI);
        if (state == S_WB_AL) begin
          RegWre    = 1'b1;
          RegDst    = (op_cls == OC_ALU_R) ? RD_RD : RD_RT;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b0;
          PCWre     = 1'b1;
        end
      end

      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = ALU_ADD;
      end

      S_MEM: begin
        if (opcode == OP_SW) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end else if (opcode == OP_LW) begin
          mRD = 1'b1;
        end
      end

      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
        RegDst    = RD_RT;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end

      S_EXE_BR: begin
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCWre  = 1'b1;
        if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
          PCSrc = PC_BR;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle CPU.
// Inputs : CLK, Reset (synchronous, active low), opcode (IR[31:26]), zero, sign.
// Outputs: PC/IR/register-file/memory enables, mux selects, ALUOp and the
//          current state for debug. PCWre is asserted only in the last cycle
//          of each instruction, so the PC updates on the edge back to IF.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        ExtSel,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc,
  output logic [2:0]  state
);

  state_t state_q;
  state_t state_d;

  logic pc_wre_raw;
  logic ir_wre_raw;
  logic reg_wre_raw;
  logic m_wr_raw;

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op_class(opcode))
          OC_ALU_R, OC_ALU_I: state_d = S_EXE_AL;
          OC_MEM:             state_d = S_EXE_LS;
          OC_BRANCH:          state_d = S_EXE_BR;
          OC_HALT:            state_d = S_ID;   // parked until reset
          default:            state_d = S_IF;   // jumps and unknown opcodes
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (pc_wre_raw),
    .PCSrc     (PCSrc),
    .IRWre     (ir_wre_raw),
    .InsMemRW  (InsMemRW),
    .ExtSel    (ExtSel),
    .RegWre    (reg_wre_raw),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .mRD       (mRD),
    .mWR       (m_wr_raw),
    .DBDataSrc (DBDataSrc)
  );

  // Architectural writes are suppressed combinationally while reset is held,
  // so aborting an instruction mid-flight leaves PC, IR, registers and memory untouched.
  assign PCWre  = pc_wre_raw  & Reset;
  assign IRWre  = ir_wre_raw  & Reset;
  assign RegWre = reg_wre_raw & Reset;
  assign mWR    = m_wr_raw    & Reset;

  assign state = state_q;

endmodule
